// File: rtl/handshake_pkg.sv
// Shared types and width helpers for the ready/valid transmitter slice.
package handshake_pkg;

  localparam int unsigned HS_WIDTH = 4;
  localparam int unsigned HS_DEPTH = 4;
  localparam int unsigned HS_PTRW  = $clog2(HS_DEPTH);
  localparam int unsigned HS_CNTW  = $clog2(HS_DEPTH + 1);

  typedef logic [HS_WIDTH-1:0] hs_word_t;

  // Storage operation resolved for one clock edge (flush handled separately).
  typedef enum logic [1:0] {
    FIFO_HOLD,
    FIFO_PUSH,
    FIFO_POP,
    FIFO_BOTH
  } fifo_op_e;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/handshake_tx_fifo.sv
// Circular word store for handshake_tx: pointers, occupancy and a flush
// that can optionally keep the currently presented head entry.
module handshake_tx_fifo
  import handshake_pkg::*;
#(
  parameter int unsigned WIDTH = HS_WIDTH,
  parameter int unsigned DEPTH = HS_DEPTH
) (
  input  logic                          CLK,
  input  logic                          ASYNCRESETN,
  input  logic                          push,
  input  logic [WIDTH-1:0]              wdata,
  input  logic                          pop,
  input  logic                          flush,
  input  logic                          keep_head,
  output logic [WIDTH-1:0]              rdata,
  output logic [cnt_width(DEPTH)-1:0]   count
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    rd_ptr_adv;
  logic [CW-1:0]    count_q;
  logic             do_write;
  fifo_op_e         op;

  assign do_write   = push && !flush;
  assign rd_ptr_adv = pop ? rd_ptr + PW'(1) : rd_ptr;

  always_comb begin
    op = FIFO_HOLD;
    if (do_write && pop) begin
      op = FIFO_BOTH;
    end else if (do_write) begin
      op = FIFO_PUSH;
    end else if (pop) begin
      op = FIFO_POP;
    end
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      rd_ptr <= rd_ptr_adv;
      if (flush) begin
        // A presented head that is not popped this edge must survive the flush.
        if (keep_head) begin
          wr_ptr  <= rd_ptr + PW'(1);
          count_q <= CW'(1);
        end else begin
          wr_ptr  <= rd_ptr_adv;
          count_q <= '0;
        end
      end else begin
        unique case (op)
          FIFO_PUSH: begin
            wr_ptr  <= wr_ptr + PW'(1);
            count_q <= count_q + CW'(1);
          end
          FIFO_POP: begin
            count_q <= count_q - CW'(1);
          end
          FIFO_BOTH: begin
            wr_ptr <= wr_ptr + PW'(1);
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (do_write) begin
      mem[wr_ptr] <= wdata;
    end
  end

  assign rdata = mem[rd_ptr];
  assign count = count_q;

endmodule

// File: rtl/handshake_tx.sv
// Ready/valid initiator: queues producer words and presents them downstream,
// holding valid/data until accepted, with an optional idle gap per transfer.
module handshake_tx
  import handshake_pkg::*;
#(
  parameter int unsigned WIDTH = HS_WIDTH,
  parameter int unsigned DEPTH = HS_DEPTH,
  parameter int unsigned GAP   = 0,
  parameter int unsigned CNTW  = 8
) (
  input  logic                         CLK,
  input  logic                         ASYNCRESETN,
  input  logic                         push_valid,
  input  logic [WIDTH-1:0]             push_data,
  output logic                         push_ready,
  input  logic                         flush,
  output logic                         handshake_valid,
  input  logic                         handshake_ready,
  output logic [WIDTH-1:0]             handshake_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [CNTW-1:0]              xfer_count
);

  localparam int unsigned CW = cnt_width(DEPTH);
  localparam int unsigned GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP);

  logic [CW-1:0]   fifo_count;
  logic [GW-1:0]   gap_cnt;
  logic [CNTW-1:0] xfer_q;
  logic            push_fire;
  logic            pop_fire;
  logic            keep_head;

  // Valid depends on registered state only, so it can never glitch on inputs.
  assign handshake_valid = (fifo_count != '0) && (gap_cnt == '0);
  assign push_ready      = (fifo_count != CW'(DEPTH));
  assign push_fire       = push_valid && push_ready;
  assign pop_fire        = handshake_valid && handshake_ready;
  assign keep_head       = handshake_valid && !handshake_ready;

  handshake_tx_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK         (CLK),
    .ASYNCRESETN (ASYNCRESETN),
    .push        (push_fire),
    .wdata       (push_data),
    .pop         (pop_fire),
    .flush       (flush),
    .keep_head   (keep_head),
    .rdata       (handshake_data),
    .count       (fifo_count)
  );

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      gap_cnt <= '0;
    end else if (pop_fire) begin
      gap_cnt <= GAP_LOAD;
    end else if (gap_cnt != '0) begin
      gap_cnt <= gap_cnt - GW'(1);
    end
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      xfer_q <= '0;
    end else if (pop_fire) begin
      xfer_q <= xfer_q + CNTW'(1);
    end
  end

  assign count      = fifo_count;
  assign xfer_count = xfer_q;

endmodule

// File: tb/tb_handshake_tx.sv
// Scoreboard bench for handshake_tx: queue-based reference model plus a
// separate gap-timing check on a GAP=2 instance.
module tb_handshake_tx;
  import handshake_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned GAP0  = 0;

  logic       CLK;
  logic       ASYNCRESETN;

  logic       push_valid;
  hs_word_t   push_data;
  logic       push_ready;
  logic       flush;
  logic       hv;
  logic       handshake_ready;
  hs_word_t   hd;
  logic [HS_CNTW-1:0] count_a;
  logic [7:0] xfer_a;

  logic       g_pv;
  hs_word_t   g_pd;
  logic       g_push_ready;
  logic       g_flush;
  logic       g_hv;
  logic       g_rdy;
  hs_word_t   g_hd;
  logic [HS_CNTW-1:0] g_count;
  logic [7:0] g_xfer;

  int n_checks = 0;
  int n_fail   = 0;

  hs_word_t exp_q[$];
  int       mgap  = 0;
  int       mxfer = 0;

  handshake_tx #(.WIDTH(4), .DEPTH(4), .GAP(0), .CNTW(8)) dut_a (
    .CLK             (CLK),
    .ASYNCRESETN     (ASYNCRESETN),
    .push_valid      (push_valid),
    .push_data       (push_data),
    .push_ready      (push_ready),
    .flush           (flush),
    .handshake_valid (hv),
    .handshake_ready (handshake_ready),
    .handshake_data  (hd),
    .count           (count_a),
    .xfer_count      (xfer_a)
  );

  handshake_tx #(.WIDTH(4), .DEPTH(4), .GAP(2), .CNTW(8)) dut_g (
    .CLK             (CLK),
    .ASYNCRESETN     (ASYNCRESETN),
    .push_valid      (g_pv),
    .push_data       (g_pd),
    .push_ready      (g_push_ready),
    .flush           (g_flush),
    .handshake_valid (g_hv),
    .handshake_ready (g_rdy),
    .handshake_data  (g_hd),
    .count           (g_count),
    .xfer_count      (g_xfer)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every accepted beat must match the oldest outstanding word.
  initial begin
    forever begin
      @(negedge CLK);
      #4;
      if (ASYNCRESETN && hv && handshake_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_underflow: got data %0d with nothing expected", hd);
        end else begin
          chk("sb_data", int'(hd), int'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic check_status(input string tag);
    bit mv;
    mv = (exp_q.size() != 0) && (mgap == 0);
    chk({tag, "_count"}, int'(count_a), exp_q.size());
    chk({tag, "_valid"}, int'(hv), int'(mv));
    chk({tag, "_push_ready"}, int'(push_ready), int'(exp_q.size() != DEPTH));
    chk({tag, "_xfer"}, int'(xfer_a), mxfer % 256);
    if (mv) chk({tag, "_data"}, int'(hd), int'(exp_q[0]));
  endtask

  // Reference rules applied to the state the DUT holds before the next edge.
  task automatic model_step(input logic pv, input hs_word_t pd, input logic fl,
                            input logic rdy);
    bit mv, pop, pr;
    mv  = (exp_q.size() != 0) && (mgap == 0);
    pop = mv && rdy;
    pr  = exp_q.size() != DEPTH;
    if (fl) begin
      if (mv) begin
        while (exp_q.size() > 1) void'(exp_q.pop_back());
      end else begin
        exp_q.delete();
      end
    end else if (pv && pr) begin
      exp_q.push_back(pd);
    end
    if (pop) begin
      mgap = GAP0;
      mxfer++;
    end else if (mgap > 0) begin
      mgap--;
    end
  endtask

  task automatic cyc(input string tag, input logic pv, input hs_word_t pd,
                     input logic fl, input logic rdy);
    @(negedge CLK);
    check_status(tag);
    push_valid      = pv;
    push_data       = pd;
    flush           = fl;
    handshake_ready = rdy;
    model_step(pv, pd, fl, rdy);
  endtask

  task automatic model_reset();
    exp_q.delete();
    mgap  = 0;
    mxfer = 0;
  endtask

  task automatic gap_test();
    int ts[$];
    hs_word_t ds[$];
    int c;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      g_pv  = 1'b1;
      g_pd  = hs_word_t'(i + 1);
      g_rdy = 1'b0;
    end
    @(negedge CLK);
    g_pv  = 1'b0;
    g_rdy = 1'b1;
    c = 0;
    while (ts.size() < 4 && c < 40) begin
      if (g_hv) begin
        ts.push_back(c);
        ds.push_back(g_hd);
      end
      @(negedge CLK);
      c++;
    end
    chk("gap_xfers_seen", ts.size(), 4);
    for (int i = 1; i < ts.size(); i++) chk("gap_spacing", ts[i] - ts[i-1], 3);
    for (int i = 0; i < ds.size(); i++) chk("gap_data", int'(ds[i]), i + 1);
    chk("gap_count_end", int'(g_count), 0);
    chk("gap_valid_end", int'(g_hv), 0);
    chk("gap_xfer_end", int'(g_xfer), 4);
    chk("gap_push_ready_end", int'(g_push_ready), 1);
    g_rdy = 1'b0;
  endtask

  initial begin
    int cycles;
    ASYNCRESETN     = 1'b0;
    push_valid      = 1'b0;
    push_data       = '0;
    flush           = 1'b0;
    handshake_ready = 1'b0;
    g_pv            = 1'b0;
    g_pd            = '0;
    g_flush         = 1'b0;
    g_rdy           = 1'b0;
    repeat (2) @(negedge CLK);
    ASYNCRESETN = 1'b1;

    // Single word latency and transfer count.
    cyc("rst", 1'b1, 4'h3, 1'b0, 1'b1);
    cyc("lat", 1'b0, 4'h0, 1'b0, 1'b1);
    cyc("lat_pop", 1'b0, 4'h0, 1'b0, 1'b0);

    // Fill to full, overflow push ignored, head held, then drain back-to-back.
    cyc("fill", 1'b1, 4'hA, 1'b0, 1'b0);
    cyc("fill", 1'b1, 4'hB, 1'b0, 1'b0);
    cyc("fill", 1'b1, 4'hC, 1'b0, 1'b0);
    cyc("fill", 1'b1, 4'hD, 1'b0, 1'b0);
    cyc("full", 1'b1, 4'hE, 1'b0, 1'b0);
    repeat (10) cyc("hold", 1'b0, 4'h0, 1'b0, 1'b0);
    repeat (4) cyc("drain", 1'b0, 4'h0, 1'b0, 1'b1);
    cyc("drained", 1'b0, 4'h0, 1'b0, 1'b0);

    // Flush while the head is presented but not accepted.
    cyc("fl3", 1'b1, 4'h5, 1'b0, 1'b0);
    cyc("fl3", 1'b1, 4'h6, 1'b0, 1'b0);
    cyc("fl3", 1'b1, 4'h7, 1'b0, 1'b0);
    cyc("flush_keep", 1'b1, 4'h9, 1'b1, 1'b0);
    cyc("kept", 1'b0, 4'h0, 1'b0, 1'b1);
    cyc("kept_pop", 1'b0, 4'h0, 1'b0, 1'b0);

    // Full FIFO with flush and pop on the same edge.
    cyc("ffill", 1'b1, 4'h1, 1'b0, 1'b0);
    cyc("ffill", 1'b1, 4'h2, 1'b0, 1'b0);
    cyc("ffill", 1'b1, 4'h3, 1'b0, 1'b0);
    cyc("ffill", 1'b1, 4'h4, 1'b0, 1'b0);
    cyc("flush_pop", 1'b0, 4'h0, 1'b1, 1'b1);
    cyc("after_flush_pop", 1'b0, 4'h0, 1'b0, 1'b0);
    cyc("idle", 1'b0, 4'h0, 1'b0, 1'b0);

    gap_test();

    // Asynchronous reset between edges while a word is being offered.
    cyc("pre_rst", 1'b1, 4'h9, 1'b0, 1'b0);
    cyc("pre_rst", 1'b1, 4'h8, 1'b0, 1'b0);
    @(negedge CLK);
    check_status("pre_rst");
    push_valid      = 1'b0;
    handshake_ready = 1'b1;
    #2;
    ASYNCRESETN = 1'b0;
    #1;
    chk("async_rst_valid", int'(hv), 0);
    chk("async_rst_count", int'(count_a), 0);
    chk("async_rst_xfer", int'(xfer_a), 0);
    chk("async_rst_push_ready", int'(push_ready), 1);
    model_reset();
    handshake_ready = 1'b0;
    @(negedge CLK);
    ASYNCRESETN = 1'b1;

    // Random traffic until 300 transfers, exercising counter wrap.
    cycles = 0;
    while (mxfer < 300 && cycles < 6000) begin
      cyc("rand", ($urandom % 4) != 0, hs_word_t'($urandom),
          ($urandom % 23) == 0, ($urandom % 3) != 0);
      cycles++;
    end
    cyc("rand_end", 1'b0, 4'h0, 1'b0, 1'b0);
    chk("rand_transfers_done", mxfer, 300);
    chk("xfer_wrap", int'(xfer_a), 44);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/handshake_tx.md
Name: handshake_tx

Overview:
- Ready/valid transmitter (initiator side) for the handshake channel that the team's bound RTL monitors check.
- Accepts words from a local producer into a small FIFO and drives `handshake_valid` / `handshake_data` toward a downstream receiver.
- Obeys the channel rules: valid is held and data stays stable until ready is sampled high.
- Optional minimum idle gap between transfers and a protocol-safe flush; sits at the producer edge of any handshake link in the design.

Parameters:
- WIDTH, 4, payload width in bits.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- GAP, 0, idle cycles forced on `handshake_valid` after each completed transfer; 0 = back-to-back.
- CNTW, 8, width of the transfer counter.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- ASYNCRESETN  input  1  asynchronous active-low reset.
- push_valid  input  1  producer offers `push_data`.
- push_data  input  WIDTH  producer payload.
- push_ready  output  1  FIFO can accept; equals (count != DEPTH).
- flush  input  1  discard queued, not-yet-presented entries.
- handshake_valid  output  1  transmitter presents `handshake_data`.
- handshake_ready  input  1  receiver accepts.
- handshake_data  output  WIDTH  head-of-FIFO payload.
- count  output  $clog2(DEPTH+1)  entries held, including the presented head.
- xfer_count  output  CNTW  completed transfers, wraps modulo 2^CNTW.

Behaviour:
- Reset (ASYNCRESETN=0, asynchronous): state is cleared.
  - Pointers, count, gap counter and xfer_count go to 0.
  - `handshake_valid` goes to 0 immediately.
  - `push_ready` goes to 1.
  - `handshake_data` is don't-care.
- Reset asserted mid-transfer drops the word with no transfer counted.
- Push: fires when push_valid && push_ready at the edge; the word is written at wr_ptr and wr_ptr increments modulo DEPTH.
- Pop: fires when handshake_valid && handshake_ready at the edge; rd_ptr increments modulo DEPTH and xfer_count increments.
- `handshake_valid` = (count != 0) && (gap_cnt == 0). It is derived from registers only, with no combinational path from any input.
- `handshake_data` = mem[rd_ptr]. It is stable while valid is high and ready is low, because the head changes only on pop.
- Latency: a push into an empty FIFO with gap_cnt=0 gives `handshake_valid`=1 on the following cycle.
- Gap counting:
  - On a pop, gap_cnt loads GAP.
  - gap_cnt decrements each cycle while nonzero.
  - Valid stays low while gap_cnt != 0, even with data queued.
  - With GAP=0, back-to-back transfers run at one word per cycle.
- Simultaneous push and pop: count is unchanged and both pointers advance. This is legal only when not full, since `push_ready` is low at count=DEPTH.
- Full: `push_ready`=0; producer data is ignored.
- Empty: `handshake_valid`=0; a ready with valid low has no effect.
- Flush, applied at the edge:
  - If handshake_valid=1 and no pop occurs this cycle, the head is retained: count=1 and wr_ptr=rd_ptr+1. Valid never drops mid-handshake.
  - If a pop occurs this cycle, or valid=0, count goes to 0 and wr_ptr=rd_ptr (after any pop).
  - A push in the same cycle as flush is discarded.
  - gap_cnt is unaffected.
- Once valid rises it must not fall until a pop or reset. Never present an X on handshake_data while valid=1.

Decomposition:
- Package `handshake_pkg`: localparams for pointer width `$clog2(DEPTH)` and count width `$clog2(DEPTH+1)`, plus a `hs_word_t` typedef sized by WIDTH.
- One natural sub-module, `handshake_tx_fifo`: circular storage with pointers, count, push/pop/flush.
- Gap counter, valid generation and xfer_count live in the `handshake_tx` top.

Test Plan:
- Reset then push 0x3 with ready=1, GAP=0 -> valid=1 with data=0x3 on the next cycle; popped on the following edge; xfer_count=1.
- Push 0xA,0xB,0xC,0xD with ready=0 -> count=4, push_ready=0, a fifth push 0xE is ignored; data holds 0xA for 10 cycles; then ready=1 gives 0xA,0xB,0xC,0xD on consecutive cycles.
- GAP=2, four words queued, ready=1 -> transfers on cycles t, t+3, t+6, t+9; valid low for exactly 2 cycles between them.
- Three words queued, valid high with 0x5, ready=0, pulse flush -> count=1, valid stays 1 with data 0x5; after ready, count=0 and valid=0.
- Full FIFO, simultaneous flush and pop -> count=0, valid=0 next cycle, push_ready=1.
- Assert ASYNCRESETN=0 between edges with valid high -> valid=0, count=0 and xfer_count=0 immediately, before the next CLK edge.
- Run 300 transfers with CNTW=8 -> xfer_count wraps to 44.
